// File: rtl/pipe_seg_fwd.sv
// pipe_seg_fwd: one pipeline segment that holds operand entries and
// applies register writeback forwarding to every value it stores.
//
// Optional feature macro: SEG_SKID_EN
//   defined   -> main + skid entry, in_ready is registered (!skid.vld)
//   undefined -> main entry only, in_ready = !main.vld || out_ready
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   flush              drop all held entries at the next edge
//   in_*               upstream valid/ready, payload, rs/rt indices, a/b values
//   out_*              downstream valid/ready, payload, rs/rt, a/b (from main)
//   wb_wen/wreg/wdata  WB_PORTS writeback ports, port k in slice k
//   out_count          number of valid held entries
module pipe_seg_fwd #(
  parameter int PAYLOAD_W = 256,
  parameter int WB_PORTS  = 2,
  parameter int REG_AW    = 5
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  input  logic [REG_AW-1:0]            in_rs,
  input  logic [REG_AW-1:0]            in_rt,
  input  logic [31:0]                  in_a,
  input  logic [31:0]                  in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [REG_AW-1:0]            out_rs,
  output logic [REG_AW-1:0]            out_rt,
  output logic [31:0]                  out_a,
  output logic [31:0]                  out_b,
  input  logic [WB_PORTS-1:0]          wb_wen,
  input  logic [WB_PORTS*REG_AW-1:0]   wb_wreg,
  input  logic [WB_PORTS*32-1:0]       wb_wdata,
  output logic [1:0]                   out_count
);

  typedef struct packed {
    logic                 vld;
    logic [PAYLOAD_W-1:0] payload;
    logic [REG_AW-1:0]    rs;
    logic [REG_AW-1:0]    rt;
    logic [31:0]          a;
    logic [31:0]          b;
  } ent_t;

  ent_t main_q, main_d, in_ent;
  logic push, pop;

  // Lowest-index matching port wins; r0 is never forwarded.
  function automatic logic [31:0] fwd(input logic [REG_AW-1:0] idx,
                                      input logic [31:0] val);
    logic [31:0] r;
    logic        hit;
    r   = val;
    hit = 1'b0;
    for (int k = 0; k < WB_PORTS; k++) begin
      if (!hit && wb_wen[k] && (wb_wreg[k*REG_AW +: REG_AW] == idx) && (idx != '0)) begin
        r   = wb_wdata[k*32 +: 32];
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  // Forwarding applied to whatever entry lands in a register this edge.
  function automatic ent_t fwd_ent(input ent_t e);
    ent_t o;
    o   = e;
    o.a = fwd(e.rs, e.a);
    o.b = fwd(e.rt, e.b);
    return o;
  endfunction

  always_comb begin
    in_ent         = '0;
    in_ent.vld     = 1'b1;
    in_ent.payload = in_payload;
    in_ent.rs      = in_rs;
    in_ent.rt      = in_rt;
    in_ent.a       = in_a;
    in_ent.b       = in_b;
  end

  assign push = in_valid && in_ready;
  assign pop  = main_q.vld && out_ready;

`ifdef SEG_SKID_EN
  ent_t skid_q, skid_d;

  // Registered ready: no path from out_ready.
  assign in_ready = !skid_q.vld;

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (pop) begin
      if (skid_q.vld) begin
        main_d = skid_q;
        skid_d = push ? in_ent : skid_q;
        skid_d.vld = push;
      end else begin
        main_d = push ? in_ent : main_q;
        main_d.vld = push;
      end
    end else if (push) begin
      if (!main_q.vld) main_d = in_ent;
      else             skid_d = in_ent;
    end
    main_d = fwd_ent(main_d);
    skid_d = fwd_ent(skid_d);
    if (flush) begin
      main_d.vld = 1'b0;
      skid_d.vld = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) skid_q <= '0;
    else         skid_q <= skid_d;
  end

  assign out_count = {1'b0, main_q.vld} + {1'b0, skid_q.vld};
`else
  assign in_ready = !main_q.vld || out_ready;

  always_comb begin
    main_d = main_q;
    if (push)     main_d = in_ent;
    else if (pop) main_d.vld = 1'b0;
    main_d = fwd_ent(main_d);
    if (flush) main_d.vld = 1'b0;
  end

  assign out_count = {1'b0, main_q.vld};
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) main_q <= '0;
    else         main_q <= main_d;
  end

  assign out_valid   = main_q.vld;
  assign out_payload = main_q.payload;
  assign out_rs      = main_q.rs;
  assign out_rt      = main_q.rt;
  assign out_a       = main_q.a;
  assign out_b       = main_q.b;

endmodule

// File: tb/tb_pipe_seg_fwd.sv
// Self-checking bench for pipe_seg_fwd: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_pipe_seg_fwd;
  localparam int PW = 256;
  localparam int NP = 2;
  localparam int AW = 5;
`ifdef SEG_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [PW-1:0] in_payload = '0;
  logic [AW-1:0] in_rs = '0, in_rt = '0;
  logic [31:0]   in_a = '0, in_b = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [PW-1:0] out_payload;
  logic [AW-1:0] out_rs, out_rt;
  logic [31:0]   out_a, out_b;
  logic [NP-1:0]    wb_wen = '0;
  logic [NP*AW-1:0] wb_wreg = '0;
  logic [NP*32-1:0] wb_wdata = '0;
  logic [1:0]    out_count;

  pipe_seg_fwd #(.PAYLOAD_W(PW), .WB_PORTS(NP), .REG_AW(AW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_rs(in_rs), .in_rt(in_rt), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_rs(out_rs), .out_rt(out_rt), .out_a(out_a), .out_b(out_b),
    .wb_wen(wb_wen), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pay;
    logic [AW-1:0] rs, rt;
    logic [31:0]   a, b;
  } ent_t;

  ent_t q[$];
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [AW-1:0] idx, input logic [31:0] v);
    if (idx == 0) return v;
    for (int k = 0; k < NP; k++)
      if (wb_wen[k] && wb_wreg[k*AW +: AW] == idx) return wb_wdata[k*32 +: 32];
    return v;
  endfunction

  function automatic logic exp_rdy();
`ifdef SEG_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  // Caller drives inputs just after a negedge; this checks outputs,
  // advances the model, and returns at the following negedge.
  task automatic tick();
    logic rdy;
    #1;
    chk("out_valid", out_valid, q.size() != 0);
    chk("out_count", out_count, q.size());
    chk("in_ready", in_ready, exp_rdy());
    if (q.size() != 0) begin
      chk("out_payload", out_payload, q[0].pay);
      chk("out_rs", out_rs, q[0].rs);
      chk("out_rt", out_rt, q[0].rt);
      chk("out_a", out_a, q[0].a);
      chk("out_b", out_b, q[0].b);
    end
    rdy = exp_rdy();
    if (flush) q.delete();
    else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && rdy) q.push_back('{in_payload, in_rs, in_rt, in_a, in_b});
    end
    foreach (q[i]) begin
      q[i].a = ref_fwd(q[i].rs, q[i].a);
      q[i].b = ref_fwd(q[i].rt, q[i].b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; wb_wen = '0; out_ready = 1;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic set_in(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [31:0] a, input logic [31:0] b);
    in_valid = 1;
    in_payload = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    in_rs = rs; in_rt = rt; in_a = a; in_b = b;
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_vld"}, out_valid, 0);
    chk({tag, "_cnt"}, out_count, 0);
    chk({tag, "_pay"}, out_payload, 0);
    chk({tag, "_rs"}, {out_rs, out_rt}, 0);
    chk({tag, "_ab"}, {out_a, out_b}, 0);
  endtask

  logic [PW-1:0] pay_save;

  initial begin
    #2;
    check_reset_zero("rst");
    @(negedge clk); @(negedge clk);
    resetn = 1;
    idle();
    #1 chk("rdy_after_rst", in_ready, 1);

    // 1-cycle latency
    set_in(5'd2, 5'd4, 32'h11, 32'h22);
    tick();
    idle();
    chk("lat_vld", out_valid, 1);
    chk("lat_a", out_a, 32'h11);
    chk("lat_cnt", out_count, 1);
    drain();

    // Stall with writeback forward into held entry
    out_ready = 0;
    set_in(5'd3, 5'd9, 32'h1234, 32'h0);
    tick();
    pay_save = out_payload;
    in_valid = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin
        wb_wen = 2'b10; wb_wreg = {5'd3, 5'd0}; wb_wdata = {32'hDEAD, 32'h0};
      end else wb_wen = '0;
      tick();
      if (c >= 2) chk("stall_a", out_a, 32'hDEAD);
    end
    chk("stall_pay", out_payload, pay_save);
    drain();

    // Capture forward, port priority
    out_ready = 0;
    set_in(5'd1, 5'd7, 32'h0, 32'h5);
    wb_wen = 2'b11; wb_wreg = {5'd7, 5'd7}; wb_wdata = {32'hBB, 32'hAA};
    tick();
    chk("prio_b", out_b, 32'hAA);
    drain();

    // Register zero is never forwarded
    out_ready = 0;
    set_in(5'd0, 5'd0, 32'h77, 32'h66);
    wb_wen = 2'b01; wb_wreg = {5'd0, 5'd0}; wb_wdata = {32'h0, 32'hFFFF};
    tick();
    chk("r0_a", out_a, 32'h77);
    drain();

`ifdef SEG_SKID_EN
    out_ready = 0;
    set_in(5'd1, 5'd2, 32'hA, 32'hA);
    tick();
    set_in(5'd1, 5'd2, 32'hB, 32'hB);
    tick();
    in_valid = 0;
    #1;
    chk("skid_rdy0", in_ready, 0);
    chk("skid_cnt2", out_count, 2);
    out_ready = 1;
    tick();
    chk("skid_B", out_a, 32'hB);
    chk("skid_rdy1", in_ready, 1);
    tick();
    chk("skid_empty", out_valid, 0);
`endif

    // Flush wins over enqueue
    out_ready = 0;
    for (int i = 0; i < CAP; i++) begin
      set_in(5'd1, 5'd1, i, i);
      tick();
    end
    set_in(5'd2, 5'd2, 32'h99, 32'h99);
    flush = 1;
    tick();
    flush = 0; in_valid = 0;
    chk("flush_vld", out_valid, 0);
    chk("flush_cnt", out_count, 0);
    tick();
    chk("flush_drop", out_valid, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        set_in(5'd3, 5'd3, 32'h1, 32'h2);
        #2 resetn = 0;
        #1 check_reset_zero("midrst");
        q.delete();
        in_valid = 0;
        #1 resetn = 1;
        @(negedge clk);
      end
      in_valid = $urandom_range(0, 3) != 0;
      in_payload = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      in_rs = $urandom_range(0, 7); in_rt = $urandom_range(0, 7);
      in_a = $urandom; in_b = $urandom;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 31) == 0;
      wb_wen = $urandom;
      wb_wreg = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wb_wdata = {$urandom, $urandom};
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_seg_fwd.md
PIPE_SEG_FWD -- requirements
Module: pipe_seg_fwd

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 256, width of opaque control/payload field.
REQ-002 SHALL have parameter WB_PORTS, default 2, number of writeback forwarding ports (1..4).
REQ-003 SHALL have parameter REG_AW, default 5, register-index width.
REQ-004 SHALL have ports: clk in 1, single clock; resetn in 1, asynchronous active-low reset.
REQ-005 SHALL have flush in 1: discard all held entries.
REQ-006 SHALL have upstream ports: in_valid in 1; in_ready out 1; in_payload in PAYLOAD_W; in_rs/in_rt in REG_AW, source indices; in_a/in_b in 32, operand values.
REQ-007 SHALL have downstream ports: out_valid out 1; out_ready in 1; out_payload out PAYLOAD_W; out_rs/out_rt out REG_AW; out_a/out_b out 32.
REQ-008 SHALL have writeback ports: wb_wen in WB_PORTS; wb_wreg in WB_PORTS*REG_AW; wb_wdata in WB_PORTS*32. Port k occupies slice k.
REQ-009 SHALL have out_count out 2: number of valid held entries.

Function
REQ-010 Entries: main (drives out_*) and skid (present only with SEG_SKID_EN); each holds valid, payload, rs, rt, a, b.
REQ-011 Transfer: in on in_valid&&in_ready; out on out_valid&&out_ready; out_valid = main.valid.
REQ-012 Accepted entry SHALL be written to main if main is empty, or main dequeues this cycle and skid is empty; otherwise to skid.
REQ-013 On main dequeue with skid valid, skid SHALL move to main in the same edge, and skid SHALL take any simultaneous input. FIFO order is always preserved.
REQ-014 Forwarding SHALL apply every cycle to every entry value being stored at the clock edge: held, moved, or newly captured.
REQ-015 Forwarding rule: if wb_wen[k] && wb_wreg[k]==rs && rs!=0, stored a = wb_wdata[k]; same for rt/b.
REQ-016 Forwarding priority: lowest-index matching port wins.
REQ-017 Index 0 SHALL never be forwarded.
REQ-018 Forwarding SHALL not alter payload, rs or rt.
REQ-019 Latency SHALL be 1 cycle, in to out, when main is empty.
REQ-020 Throughput SHALL be 1 entry/cycle when out_ready is held high.
REQ-021 flush SHALL clear all valid bits at the next edge and SHALL win over simultaneous enqueue; the input is dropped and in_ready is unaffected that cycle.
REQ-022 Data fields of invalid entries SHALL be don't-care, except after reset.
REQ-023 out_count SHALL equal main.valid + skid.valid.

Reset
REQ-024 resetn low SHALL asynchronously clear all valid bits and zero all data fields.
REQ-025 During reset: out_valid=0, out_count=0, out_payload/out_rs/out_rt/out_a/out_b=0.
REQ-026 in_ready SHALL be 1 after reset release.
REQ-027 Reset asserted mid-transfer SHALL lose the entry with no partial update.

Configuration
REQ-028 Macro SEG_SKID_EN defined: two entries; in_ready = !skid.valid, which is a registered signal with no combinational path from out_ready.
REQ-029 SEG_SKID_EN undefined: main entry only; in_ready = !main.valid || out_ready; out_count never exceeds 1; forwarding and flush unchanged.

Verification
REQ-030 Reset, then in_valid=1 with in_a=0x11 and out_ready=1 -> out_valid=1 next cycle, out_a=0x11, out_count=1.
REQ-031 Stall: out_ready=0 for 5 cycles with entry rs=3; wb_wen[1]=1, wb_wreg[1]=3, wb_wdata[1]=0xDEAD in cycle 2 -> out_a=0xDEAD from cycle 3, payload unchanged.
REQ-032 Capture forward: enqueue rt=7 with in_b=0x5 while wb port0 writes r7=0xAA and port1 writes r7=0xBB -> out_b=0xAA.
REQ-033 Zero register: enqueue rs=0 while wb writes r0=0xFFFF -> out_a equals in_a.
REQ-034 With SEG_SKID_EN: out_ready=0, push A then B -> in_ready=0, out_count=2; raise out_ready -> A then B out on consecutive cycles, in_ready=1 the cycle after A leaves.
REQ-035 Flush with out_count=2 and simultaneous in_valid=1 -> next cycle out_valid=0, out_count=0; the input is not stored.
